// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//   Registered writeback stage behind the 32-bit ALU. Captures the result,
//   op-qualified flags and ALUop into a 2-entry FIFO with valid/ready on both
//   sides, and keeps a sticky overflow status bit.
//
//   Optional feature macro: ALU_RESULT_STATS_EN
//     defined   -> saturating counters stat_ops / stat_ovf are built
//     undefined -> stat_ops / stat_ovf are tied to 0 (ports unchanged)
//
// Ports
//   clk, resetn            clock (rising edge), async active-low reset
//   in_valid / in_ready    producer handshake (in_ready registered)
//   in_aluop, in_result    ALUop and ALU result
//   in_overflow/carryout/zero  raw ALU flags
//   out_valid / out_ready  consumer handshake
//   out_result, out_flags  head entry; flags = {overflow, carry, zero}
//   ovf_sticky, sticky_clr sticky qualified overflow and its sync clear
//   stat_ops, stat_ovf     accepted-entry / qualified-overflow counters
// ----------------------------------------------------------------------------
module alu_result_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_aluop,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  in_overflow,
   input  logic                  in_carryout,
   input  logic                  in_zero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [2:0]            out_flags,
   output logic                  ovf_sticky,
   input  logic                  sticky_clr,
   output logic [CNT_WIDTH-1:0]  stat_ops,
   output logic [CNT_WIDTH-1:0]  stat_ovf
);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [2:0]            flags;   // {overflow, carry, zero}
   } entry_t;

   state_t state, state_nxt;
   entry_t head, tail, head_nxt, tail_nxt, in_entry;
   logic   push, pop, arith_op;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Only ADD/SUB produce meaningful overflow/carry; zero always passes.
   always_comb begin
      arith_op        = (in_aluop == OP_ADD) || (in_aluop == OP_SUB);
      in_entry.result = in_result;
      in_entry.flags  = {in_overflow & arith_op, in_carryout & arith_op, in_zero};
   end

   // Occupancy FSM: next state and next head/tail contents.
   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      tail_nxt  = tail;
      case (state)
         ST_EMPTY: begin
            if (push) begin
               state_nxt = ST_ONE;
               head_nxt  = in_entry;
            end
         end
         ST_ONE: begin
            case ({push, pop})
               2'b10: begin
                  state_nxt = ST_FULL;
                  tail_nxt  = in_entry;
               end
               2'b01: state_nxt = ST_EMPTY;
               2'b11: head_nxt  = in_entry;   // head consumed, replaced by new entry
               default: ;
            endcase
         end
         ST_FULL: begin
            if (pop) begin
               state_nxt = ST_ONE;
               head_nxt  = tail;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // State, storage and handshake registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_EMPTY;
         head      <= '0;
         tail      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         head      <= head_nxt;
         tail      <= tail_nxt;
         in_ready  <= (state_nxt != ST_FULL);
         out_valid <= (state_nxt != ST_EMPTY);
      end
   end

   assign out_result = head.result;
   assign out_flags  = head.flags;

   // Sticky overflow: a qualifying push wins over a same-cycle clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                       ovf_sticky <= 1'b0;
      else if (push && in_entry.flags[2]) ovf_sticky <= 1'b1;
      else if (sticky_clr)                ovf_sticky <= 1'b0;
   end

`ifdef ALU_RESULT_STATS_EN
   // Saturating statistics counters, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_ops <= '0;
         stat_ovf <= '0;
      end else if (push) begin
         if (stat_ops != '1) stat_ops <= stat_ops + CNT_WIDTH'(1);
         if (in_entry.flags[2] && (stat_ovf != '1)) stat_ovf <= stat_ovf + CNT_WIDTH'(1);
      end
   end
`else
   assign stat_ops = '0;
   assign stat_ovf = '0;
`endif

endmodule
